// File: rtl/gf_mult_pkg.sv
// Shared types for the digit-serial GF(2)[x] / integer multiplier.
// FSM state encoding and product-mode selector values.
package gf_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam logic GF_MODE_CLMUL = 1'b1;
   localparam logic GF_MODE_INT   = 1'b0;

endpackage

// File: rtl/gf_digit_mac.sv
// One digit step: partial product of a by a DIGIT_WIDTH slice of b,
// shifted into place and folded into the accumulator (XOR or add).
module gf_digit_mac
   import gf_mult_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DIGIT_WIDTH = 4,
   parameter int IDX_W       = 3
) (
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DIGIT_WIDTH-1:0]  digit,
   input  logic [2*DATA_WIDTH-1:0] acc,
   input  logic [IDX_W-1:0]        shift,
   input  logic                    gf_option,
   output logic [2*DATA_WIDTH-1:0] next_acc
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int SW = $clog2(PW) + 1;

   logic [PW-1:0] row;
   logic [PW-1:0] pp_x;
   logic [PW-1:0] pp_i;
   logic [SW-1:0] amt;

   always_comb begin
      row  = '0;
      pp_x = '0;
      pp_i = '0;
      for (int j = 0; j < DIGIT_WIDTH; j++) begin
         row = {{DATA_WIDTH{1'b0}}, a} << j;
         if (digit[j]) begin
            pp_x = pp_x ^ row;
            pp_i = pp_i + row;
         end
      end
      amt = SW'(shift) * SW'(DIGIT_WIDTH);
      // Digit products never exceed PW bits, so the add cannot wrap.
      if (gf_option == GF_MODE_CLMUL) begin
         next_acc = acc ^ (pp_x << amt);
      end else begin
         next_acc = acc + (pp_i << amt);
      end
   end

endmodule

// File: rtl/gf_digit_serial_mult.sv
// Digit-serial carry-less / unsigned multiplier, LSB digit of b first,
// returning the full unreduced 2*DATA_WIDTH-bit product over valid/ready.
module gf_digit_serial_mult
   import gf_mult_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int DIGIT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    gf_option,
   input  logic [DATA_WIDTH-1:0]   a,
   input  logic [DATA_WIDTH-1:0]   b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out,
   output logic                    busy
);

   localparam int NDIG  = DATA_WIDTH / DIGIT_WIDTH;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

   generate
      if (DATA_WIDTH < 2 || DIGIT_WIDTH < 1 ||
          (DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_cfg
         $error("DIGIT_WIDTH must divide DATA_WIDTH (>= 2)");
      end
   endgenerate

   state_t                  state_q;
   state_t                  state_d;
   logic [IDX_W-1:0]        k_q;
   logic [DATA_WIDTH-1:0]   a_q;
   logic [DATA_WIDTH-1:0]   b_q;
   logic                    mode_q;
   logic [2*DATA_WIDTH-1:0] acc_q;
   logic [2*DATA_WIDTH-1:0] acc_d;
   logic                    accept;

   assign accept = in_valid && in_ready;

   gf_digit_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .DIGIT_WIDTH(DIGIT_WIDTH),
      .IDX_W      (IDX_W)
   ) u_mac (
      .a        (a_q),
      .digit    (b_q[DIGIT_WIDTH-1:0]),
      .acc      (acc_q),
      .shift    (k_q),
      .gf_option(mode_q),
      .next_acc (acc_d)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (k_q == LAST) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= GF_MODE_INT;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= gf_option;
            acc_q  <= '0;
            k_q    <= '0;
         end else if (state_q == BUSY) begin
            // b is shifted down so the active digit is always at bit 0.
            acc_q <= acc_d;
            b_q   <= b_q >> DIGIT_WIDTH;
            k_q   <= (k_q == LAST) ? '0 : k_q + IDX_W'(1);
         end
      end
   end

   assign out = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_gf_digit_serial_mult.sv
// Bench for gf_digit_serial_mult: an 8/2 instance for directed timing
// scenarios and a 32/4 instance for randomized product checks.
module tb_gf_digit_serial_mult;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic        in_valid, in_ready, gf_option;
   logic [7:0]  a, b;
   logic        out_valid, out_ready, busy;
   logic [15:0] out;

   logic        w_in_valid, w_in_ready, w_gf_option;
   logic [31:0] w_a, w_b;
   logic        w_out_valid, w_out_ready, w_busy;
   logic [63:0] w_out;

   int errors = 0;
   int checks = 0;

   gf_digit_serial_mult #(.DATA_WIDTH(8), .DIGIT_WIDTH(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .gf_option(gf_option), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .busy(busy)
   );

   gf_digit_serial_mult #(.DATA_WIDTH(32), .DIGIT_WIDTH(4)) u_dut32 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(w_in_valid), .in_ready(w_in_ready),
      .gf_option(w_gf_option), .a(w_a), .b(w_b),
      .out_valid(w_out_valid), .out_ready(w_out_ready),
      .out(w_out), .busy(w_busy)
   );

   // Reference: textbook shift-and-XOR over every bit, and native multiply.
   function automatic logic [63:0] ref_prod(input logic m,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
      logic [63:0] r;
      r = '0;
      if (m) begin
         for (int i = 0; i < 32; i++)
            if (y[i]) r = r ^ ({32'b0, x} << i);
      end else begin
         r = {32'b0, x} * {32'b0, y};
      end
      return r;
   endfunction

   task automatic op8(input logic m, input logic [7:0] x,
                      input logic [7:0] y,
                      output logic [15:0] res, output int lat);
      int n;
      @(negedge clk);
      gf_option = m; a = x; b = y;
      in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk); n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL accept8: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk); lat++;
      end
      res = out;
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL done8: out_valid=%b required 1", out_valid);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic op32(input logic m, input logic [31:0] x,
                       input logic [31:0] y,
                       output logic [63:0] res, output int lat);
      int n;
      @(negedge clk);
      w_gf_option = m; w_a = x; w_b = y;
      w_in_valid = 1'b1; w_out_ready = 1'b0;
      n = 0;
      while (!w_in_ready && n < 50) begin
         @(negedge clk); n++;
      end
      if (!w_in_ready) begin
         checks++; errors++;
         $display("FAIL accept32: in_ready=%b required 1", w_in_ready);
      end
      @(negedge clk);
      w_in_valid = 1'b0;
      lat = 1;
      while (!w_out_valid && lat < 50) begin
         @(negedge clk); lat++;
      end
      res = w_out;
      if (!w_out_valid) begin
         checks++; errors++;
         $display("FAIL done32: out_valid=%b required 1", w_out_valid);
      end
      w_out_ready = 1'b1;
      @(negedge clk);
      w_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          busy !== 1'b0 || out !== 16'h0) begin
         errors++;
         $display("FAIL reset8: rdy=%b vld=%b busy=%b out=%h required 1 0 0 0",
                  in_ready, out_valid, busy, out);
      end
      checks++;
      if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 ||
          w_busy !== 1'b0 || w_out !== 64'h0) begin
         errors++;
         $display("FAIL reset32: rdy=%b vld=%b busy=%b out=%h required 1 0 0 0",
                  w_in_ready, w_out_valid, w_busy, w_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clmul_basic();
      logic [15:0] r;
      int lat;
      op8(1'b1, 8'h57, 8'h83, r, lat);
      checks++;
      if (r !== 16'h2B79) begin
         errors++;
         $display("FAIL clmul_57_83: got %h required 2b79", r);
      end
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("FAIL latency8: got %0d required 5", lat);
      end
   endtask

   task automatic test_int_basic();
      logic [15:0] r;
      int lat;
      op8(1'b0, 8'h57, 8'h83, r, lat);
      checks++;
      if (r !== 16'h2C85) begin
         errors++;
         $display("FAIL int_57_83: got %h required 2c85", r);
      end
      op8(1'b1, 8'hFF, 8'hFF, r, lat);
      checks++;
      if (r !== 16'h5555) begin
         errors++;
         $display("FAIL clmul_ff_ff: got %h required 5555", r);
      end
      op8(1'b0, 8'h00, 8'hC3, r, lat);
      checks++;
      if (r !== 16'h0 || lat !== 5) begin
         errors++;
         $display("FAIL zero_a: got %h lat %0d required 0 lat 5", r, lat);
      end
      op8(1'b1, 8'hA5, 8'h00, r, lat);
      checks++;
      if (r !== 16'h0 || lat !== 5) begin
         errors++;
         $display("FAIL zero_b: got %h lat %0d required 0 lat 5", r, lat);
      end
   endtask

   task automatic test_stall();
      int n;
      @(negedge clk);
      gf_option = 1'b0; a = 8'hFF; b = 8'hFF;
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      a = 8'h12; b = 8'h34; gf_option = 1'b1;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk); n++;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out !== 16'hFE01 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d]: vld=%b out=%h rdy=%b required 1 fe01 0",
                     i, out_valid, out, in_ready);
         end
         if (i < 2) @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: vld=%b rdy=%b required 0 1",
                  out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  x1, y1, x2, y2;
      logic [15:0] e1, e2;
      int t1, t2, nacc, nres;
      logic took;
      x1 = 8'($urandom); y1 = 8'($urandom);
      x2 = 8'($urandom); y2 = 8'($urandom);
      e1 = 16'(ref_prod(1'b0, {24'b0, x1}, {24'b0, y1}));
      e2 = 16'(ref_prod(1'b1, {24'b0, x2}, {24'b0, y2}));
      t1 = -1; t2 = -1; nacc = 0; nres = 0;
      @(negedge clk);
      gf_option = 1'b0; a = x1; b = y1;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         took = in_valid && in_ready;
         if (took) begin
            if (nacc == 0) t1 = cyc; else t2 = cyc;
            nacc++;
         end
         if (out_valid) begin
            nres++;
            checks++;
            if (out !== (nres == 1 ? e1 : e2)) begin
               errors++;
               $display("FAIL b2b_res%0d: got %h required %h",
                        nres, out, nres == 1 ? e1 : e2);
            end
            if (nres == 1) begin
               gf_option = 1'b1; a = x2; b = y2;
            end else begin
               in_valid = 1'b0;
               break;
            end
         end else if (!took && nacc > 0) begin
            gf_option = ~gf_option;
            a = 8'($urandom); b = 8'($urandom);
         end
         @(negedge clk);
      end
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (nres != 2 || t2 - t1 != 6) begin
         errors++;
         $display("FAIL b2b_interval: results %0d gap %0d required 2 gap 6",
                  nres, t2 - t1);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      int lat;
      @(negedge clk);
      gf_option = 1'b0; a = 8'hE7; b = 8'h9D;
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: busy=%b required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
          out !== 16'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b vld=%b out=%h busy=%b required 1 0 0 0",
                  in_ready, out_valid, out, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      op8(1'b0, 8'hE7, 8'h9D, r, lat);
      checks++;
      if (r !== 16'hE7 * 16'h9D) begin
         errors++;
         $display("FAIL after_reset: got %h required %h", r, 16'hE7 * 16'h9D);
      end
   endtask

   task automatic test_random32();
      logic [31:0] x, y;
      logic [63:0] r, e;
      int lat;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1500; i++) begin
            x = $urandom; y = $urandom;
            if (i == 0) x = 32'h0;
            if (i == 1) y = 32'h0;
            if (i == 2) begin x = '1; y = '1; end
            if (i % 97 == 5) x = '1;
            e = ref_prod(m[0], x, y);
            op32(m[0], x, y, r, lat);
            checks++;
            if (r !== e || lat !== 9) begin
               errors++;
               $display("FAIL rand32 m=%0d a=%h b=%h: got %h lat %0d required %h lat 9",
                        m, x, y, r, lat, e);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; gf_option = 1'b0;
      a = '0; b = '0;
      w_in_valid = 1'b0; w_out_ready = 1'b0; w_gf_option = 1'b0;
      w_a = '0; w_b = '0;
      test_reset();
      test_clmul_basic();
      test_int_basic();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random32();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
